// File: rtl/multi_step_gen.sv
// Multi-channel step-pulse generator: each channel turns a trigger edge into a
// programmable burst (or free-running train) of one-clock step pulses.
module multi_step_gen #(
  parameter int NUM_CH = 4,
  parameter int PER_W  = 16,
  parameter int CNT_W  = 8
) (
  input  logic                    clk_i,
  input  logic                    rst_n_i,
  input  logic [NUM_CH-1:0]       sp_i,
  input  logic [NUM_CH-1:0]       abort_i,
  input  logic [NUM_CH-1:0]       mode_i,
  input  logic [NUM_CH*PER_W-1:0] period_i,
  input  logic [NUM_CH*CNT_W-1:0] num_steps_i,
  output logic [NUM_CH-1:0]       step_o,
  output logic [NUM_CH-1:0]       busy_o,
  output logic [NUM_CH-1:0]       done_o,
  output logic [NUM_CH*CNT_W-1:0] count_o
);

  // state | meaning
  // IDLE  | waiting for a trigger edge (also the NUM_STEPS=0 done cycle)
  // RUN   | issuing steps; timer counts down to the next step
  typedef enum logic {IDLE, RUN} state_t;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    state_t           state_q;
    logic             sp_low_q;
    logic             mode_q;
    logic             step_q;
    logic             busy_q;
    logic             done_q;
    logic [PER_W-1:0] per_q;
    logic [PER_W-1:0] timer_q;
    logic [CNT_W-1:0] num_q;
    logic [CNT_W-1:0] cnt_q;
    logic [PER_W-1:0] per_in;
    logic [CNT_W-1:0] num_in;
    logic             trig;
    logic             idle_like;

    assign per_in    = (period_i[g*PER_W +: PER_W] == '0) ? PER_W'(1)
                                                          : period_i[g*PER_W +: PER_W];
    assign num_in    = num_steps_i[g*CNT_W +: CNT_W];
    // sp_low_q clears on reset, so SP already high at release is not an edge
    assign trig      = sp_i[g] & sp_low_q;
    // The final-step cycle of a burst accepts a trigger as if already idle
    assign idle_like = (state_q == IDLE) | done_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
        state_q  <= IDLE;
        sp_low_q <= 1'b0;
        mode_q   <= 1'b0;
        step_q   <= 1'b0;
        busy_q   <= 1'b0;
        done_q   <= 1'b0;
        per_q    <= '0;
        timer_q  <= '0;
        num_q    <= '0;
        cnt_q    <= '0;
      end else begin
        sp_low_q <= ~sp_i[g];
        if (abort_i[g]) begin
          state_q <= IDLE;
          step_q  <= 1'b0;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end else if (idle_like) begin
          if (trig) begin
            mode_q <= mode_i[g];
            per_q  <= per_in;
            num_q  <= num_in;
            if (!mode_i[g] && (num_in == '0)) begin
              state_q <= IDLE;
              step_q  <= 1'b0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              cnt_q   <= '0;
            end else begin
              state_q <= RUN;
              step_q  <= 1'b1;
              busy_q  <= 1'b1;
              done_q  <= !mode_i[g] && (num_in == CNT_W'(1));
              cnt_q   <= CNT_W'(1);
              timer_q <= per_in - PER_W'(1);
            end
          end else begin
            state_q <= IDLE;
            step_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
          end
        end else if (timer_q == '0) begin
          step_q  <= 1'b1;
          cnt_q   <= cnt_q + CNT_W'(1);
          timer_q <= per_q - PER_W'(1);
          done_q  <= !mode_q && ((cnt_q + CNT_W'(1)) == num_q);
        end else begin
          step_q  <= 1'b0;
          timer_q <= timer_q - PER_W'(1);
          done_q  <= 1'b0;
        end
      end
    end

    assign step_o[g]                 = step_q;
    assign busy_o[g]                 = busy_q;
    assign done_o[g]                 = done_q;
    assign count_o[g*CNT_W +: CNT_W] = cnt_q;
  end

endmodule

// File: tb/tb_multi_step_gen.sv
// Scoreboard bench for multi_step_gen: a closed-form per-burst waveform model
// pushes expected outputs for each edge, which are popped and compared after it.
module tb_multi_step_gen;
  localparam int NUM_CH = 4;
  localparam int PER_W  = 16;
  localparam int CNT_W  = 8;

  logic                    clk_i = 1'b0;
  logic                    rst_n_i = 1'b0;
  logic [NUM_CH-1:0]       sp_i = '0;
  logic [NUM_CH-1:0]       abort_i = '0;
  logic [NUM_CH-1:0]       mode_i = '0;
  logic [NUM_CH*PER_W-1:0] period_i = '0;
  logic [NUM_CH*CNT_W-1:0] num_steps_i = '0;
  logic [NUM_CH-1:0]       step_o;
  logic [NUM_CH-1:0]       busy_o;
  logic [NUM_CH-1:0]       done_o;
  logic [NUM_CH*CNT_W-1:0] count_o;

  multi_step_gen #(.NUM_CH(NUM_CH), .PER_W(PER_W), .CNT_W(CNT_W)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .sp_i(sp_i), .abort_i(abort_i),
    .mode_i(mode_i), .period_i(period_i), .num_steps_i(num_steps_i),
    .step_o(step_o), .busy_o(busy_o), .done_o(done_o), .count_o(count_o)
  );

  always #5 clk_i = ~clk_i;

  int n_cmp = 0;
  int n_err = 0;
  int edge_n = 0;
  logic [43:0] exp_q[$];

  // burst descriptors: start edge, period, steps, mode, abort edge, valid, held count
  int st[NUM_CH], per[NUM_CH], nst[NUM_CH], md[NUM_CH], ab[NUM_CH], val[NUM_CH], held[NUM_CH];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s @edge %0d: got %h expected %h", tag, edge_n, obs, exp);
    end
  endtask

  function automatic int cnt_raw(int c, int m);
    int p;
    int last;
    p = (per[c] < 1) ? 1 : per[c];
    if (md[c] != 0) return ((m / p) + 1) % 256;
    if (nst[c] == 0) return 0;
    last = (nst[c] - 1) * p;
    if (m <= last) return m / p + 1;
    return nst[c];
  endfunction

  function automatic logic [43:0] exp_vec(int e);
    logic [3:0]  s, b, d;
    logic [31:0] cv;
    int m, p, last;
    s = '0; b = '0; d = '0; cv = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (val[c] == 0) begin
        cv[c*8 +: 8] = 8'(held[c]);
      end else begin
        m = e - st[c];
        p = (per[c] < 1) ? 1 : per[c];
        if (ab[c] >= 0 && e >= ab[c]) begin
          cv[c*8 +: 8] = 8'(cnt_raw(c, ab[c] - 1 - st[c]));
        end else if (md[c] != 0) begin
          s[c] = (m % p) == 0;
          b[c] = 1'b1;
          cv[c*8 +: 8] = 8'(cnt_raw(c, m));
        end else if (nst[c] == 0) begin
          d[c] = (m == 0);
        end else begin
          last = (nst[c] - 1) * p;
          if (m <= last) begin
            s[c] = (m % p) == 0;
            b[c] = 1'b1;
            d[c] = (m == last);
          end
          cv[c*8 +: 8] = 8'(cnt_raw(c, m));
        end
      end
    end
    return {s, b, d, cv};
  endfunction

  task automatic tick(input string tag);
    logic [43:0] e;
    exp_q.push_back(exp_vec(edge_n + 1));
    @(posedge clk_i);
    edge_n++;
    @(negedge clk_i);
    e = exp_q.pop_front();
    chk(tag, 64'({step_o, busy_o, done_o, count_o}), 64'(e));
  endtask

  task automatic ticks(input int n, input string tag);
    for (int i = 0; i < n; i++) tick(tag);
  endtask

  task automatic set_cfg(input int c, input int p, input int n, input int mo);
    period_i[c*PER_W +: PER_W]    = PER_W'(p);
    num_steps_i[c*CNT_W +: CNT_W] = CNT_W'(n);
    mode_i[c]                     = mo[0];
  endtask

  // Trigger that the model expects to be accepted on the next edge
  task automatic arm(input int c, input int p, input int n, input int mo);
    set_cfg(c, p, n, mo);
    sp_i[c] = 1'b1;
    st[c] = edge_n + 1; per[c] = p; nst[c] = n; md[c] = mo; ab[c] = -1; val[c] = 1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    for (int c = 0; c < NUM_CH; c++) begin
      st[c] = 0; per[c] = 1; nst[c] = 0; md[c] = 0; ab[c] = -1; val[c] = 0; held[c] = 0;
    end
    @(negedge clk_i);
    @(negedge clk_i);
    chk("reset", 64'({step_o, busy_o, done_o, count_o}), 64'(0));
    rst_n_i = 1'b1;
    ticks(2, "idle");

    // basic burst; config changes after trigger must not matter
    arm(0, 3, 5, 0);
    tick("ch0_burst");
    sp_i[0] = 1'b0;
    set_cfg(0, 7, 2, 1);
    ticks(15, "ch0_burst");

    // mid-burst retrigger is ignored
    arm(0, 3, 5, 0);
    tick("retrig");
    sp_i[0] = 1'b0;
    ticks(4, "retrig");
    sp_i[0] = 1'b1;
    tick("retrig");
    sp_i[0] = 1'b0;
    ticks(10, "retrig");

    // trigger on the edge ending the final-step cycle restarts back-to-back
    arm(0, 2, 3, 0);
    tick("b2b");
    sp_i[0] = 1'b0;
    ticks(4, "b2b");
    arm(0, 1, 2, 0);
    tick("b2b");
    sp_i[0] = 1'b0;
    ticks(4, "b2b");

    // abort and trigger together while idle: nothing starts
    set_cfg(3, 2, 3, 0);
    sp_i[3] = 1'b1;
    abort_i[3] = 1'b1;
    tick("abort_sp");
    sp_i[3] = 1'b0;
    abort_i[3] = 1'b0;
    ticks(3, "abort_sp");

    // period 1, period 0 (same waveform), zero-length burst
    arm(1, 1, 4, 0);
    tick("ch1_p1");
    sp_i[1] = 1'b0;
    ticks(5, "ch1_p1");
    arm(1, 0, 4, 0);
    tick("ch1_p0");
    sp_i[1] = 1'b0;
    ticks(5, "ch1_p0");
    arm(1, 3, 0, 0);
    tick("ch1_n0");
    sp_i[1] = 1'b0;
    ticks(3, "ch1_n0");

    // free-running with count wrap, then abort
    arm(2, 2, 0, 1);
    tick("ch2_free");
    sp_i[2] = 1'b0;
    ticks(600, "ch2_free");
    ab[2] = edge_n + 1;
    abort_i[2] = 1'b1;
    tick("ch2_abort");
    abort_i[2] = 1'b0;
    ticks(3, "ch2_abort");

    // abort beats the pending final step
    arm(3, 2, 2, 0);
    tick("abort_final");
    sp_i[3] = 1'b0;
    tick("abort_final");
    ab[3] = edge_n + 1;
    abort_i[3] = 1'b1;
    tick("abort_final");
    abort_i[3] = 1'b0;
    ticks(2, "abort_final");

    // all channels on one edge
    arm(0, 3, 5, 0);
    arm(1, 1, 4, 0);
    arm(2, 2, 3, 0);
    arm(3, 5, 2, 0);
    tick("all_ch");
    sp_i = '0;
    ticks(14, "all_ch");

    // reset mid-burst, then SP held high through release
    arm(0, 3, 5, 0);
    tick("pre_rst");
    sp_i[0] = 1'b0;
    ticks(6, "pre_rst");
    rst_n_i = 1'b0;
    #1;
    chk("rst_async", 64'({step_o, busy_o, done_o, count_o}), 64'(0));
    sp_i[0] = 1'b1;
    for (int c = 0; c < NUM_CH; c++) begin
      val[c] = 0; held[c] = 0;
    end
    @(negedge clk_i);
    rst_n_i = 1'b1;
    ticks(3, "post_rst");
    sp_i[0] = 1'b0;
    tick("post_rst");
    arm(0, 1, 1, 0);
    tick("single");
    sp_i[0] = 1'b0;
    ticks(2, "single");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
